// File: rtl/lane_capture_fifo.sv
// lane_capture_fifo: small valid/ready FIFO for lane words with sticky overflow and flush
module lane_capture_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_data_in,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data_out,
  output logic             o_valid,
  input  logic             i_ready,
  input  logic             i_clear,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overflow
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic push, pop;
  assign o_ready = count != CNT_W'(DEPTH);
  assign o_valid = count != '0;
  assign push = i_valid && o_ready;
  assign pop = o_valid && i_ready;
  assign o_count = count;
  assign o_data_out = o_valid ? mem[rd_ptr] : '0;
  // storage is unobservable when empty, so it needs no reset
  always_ff @(posedge clk)
    if (push && !i_clear) mem[wr_ptr] <= i_data_in;
  // pointers, occupancy and sticky overflow; flush beats every other action
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      o_overflow <= 1'b0;
    end else if (i_clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= (push && !pop) ? count + CNT_W'(1) : (pop && !push) ? count - CNT_W'(1) : count;
      if (i_valid && !o_ready) o_overflow <= 1'b1;
    end
endmodule

// File: tb/tb_lane_capture_fifo.sv
// tb_lane_capture_fifo: queue-model checking of lane_capture_fifo with directed and random traffic
module tb_lane_capture_fifo;
  localparam int WIDTH = 2;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  logic clk = 0, rst_n = 0;
  logic [WIDTH-1:0] i_data_in = '0;
  logic i_valid = 0, i_ready = 0, i_clear = 0;
  logic o_ready, o_valid, o_overflow;
  logic [WIDTH-1:0] o_data_out;
  logic [CNT_W-1:0] o_count;
  int total = 0, bad = 0;
  logic [WIDTH-1:0] q[$];
  bit ovf = 0;

  lane_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_data_in(i_data_in), .i_valid(i_valid),
    .o_ready(o_ready), .o_data_out(o_data_out), .o_valid(o_valid),
    .i_ready(i_ready), .i_clear(i_clear), .o_count(o_count), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference: a plain queue of accepted words plus a sticky overflow bit
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      ovf = 0;
    end else if (i_clear) begin
      q.delete();
      ovf = 0;
    end else begin
      automatic bit full = q.size() == DEPTH;
      automatic bit do_pop = q.size() > 0 && i_ready;
      automatic bit do_push = i_valid && !full;
      if (i_valid && full) ovf = 1;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(i_data_in);
    end
  end

  // every falling edge, all outputs must match the model
  always @(negedge clk) begin
    chk("valid", o_valid, q.size() != 0);
    chk("ready", o_ready, q.size() != DEPTH);
    chk("count", o_count, q.size());
    chk("data", o_data_out, q.size() != 0 ? q[0] : 0);
    chk("overflow", o_overflow, ovf);
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit r, input bit c);
    i_valid = v;
    i_data_in = d;
    i_ready = r;
    i_clear = c;
  endtask

  initial begin
    logic [WIDTH-1:0] pat [4];
    pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b11; pat[3] = 2'b00;
    step();
    step();
    rst_n = 1;
    step();
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_count", o_count, 0);
    chk("rst_data", o_data_out, 0);
    chk("rst_ovf", o_overflow, 0);
    // fill while consumer stalls
    for (int i = 0; i < 4; i++) begin
      drive(1, pat[i], 0, 0);
      step();
    end
    chk("full_count", o_count, 4);
    chk("full_ready", o_ready, 0);
    // offer a word while full
    drive(1, 2'b11, 0, 0);
    step();
    chk("ovf_set", o_overflow, 1);
    chk("ovf_count", o_count, 4);
    chk("ovf_head", o_data_out, 2'b01);
    drive(0, 0, 0, 1);
    step();
    chk("clr_count", o_count, 0);
    chk("clr_ovf", o_overflow, 0);
    // refill then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1, pat[i], 0, 0);
      step();
    end
    drive(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", o_data_out, pat[i]);
      step();
    end
    chk("drain_empty", o_valid, 0);
    // streaming through pointer wrap
    for (int i = 0; i < 10; i++) begin
      drive(1, WIDTH'(i), 1, 0);
      step();
      chk("stream_count", o_count, 1);
      chk("stream_data", o_data_out, i & 3);
    end
    drive(0, 0, 1, 0);
    step();
    // clear wins over simultaneous push and pop
    drive(1, 2'b01, 0, 0);
    step();
    drive(1, 2'b11, 0, 0);
    step();
    chk("pre_clr_count", o_count, 2);
    drive(1, 2'b10, 1, 1);
    step();
    chk("prio_count", o_count, 0);
    chk("prio_valid", o_valid, 0);
    drive(0, 0, 1, 0);
    step();
    chk("prio_gone", o_valid, 0);
    // asynchronous reset between edges
    for (int i = 0; i < 3; i++) begin
      drive(1, pat[i], 0, 0);
      step();
    end
    drive(0, 0, 0, 0);
    chk("pre_rst_count", o_count, 3);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_ready", o_ready, 1);
    chk("arst_count", o_count, 0);
    chk("arst_data", o_data_out, 0);
    step();
    rst_n = 1;
    step();
    // random traffic with phases of heavy stall
    for (int i = 0; i < 600; i++) begin
      automatic bit stall = (i / 50) % 2 == 1;
      drive($urandom_range(0, 3) != 0, WIDTH'($urandom), stall ? $urandom_range(0, 4) == 0 : $urandom_range(0, 1) == 1,
            $urandom_range(0, 40) == 0);
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
